// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the Execute -> Writeback interface.
// Holds the result bundle layout, the writeback FSM state and GPR constants.
package pipeline_pkg;

  localparam int BUNDLE_DATA_W = 64;
  localparam int BUNDLE_REG_AW = 4;
  localparam int BUNDLE_RIP_W  = 32;

  localparam int NUM_GPRS = 16;
  localparam logic [BUNDLE_REG_AW-1:0] REG_RAX = 4'd0;
  localparam logic [BUNDLE_REG_AW-1:0] REG_RDX = 4'd2;

  typedef struct packed {
    logic [BUNDLE_DATA_W-1:0] result;
    logic [BUNDLE_DATA_W-1:0] resultSpecial;
    logic [BUNDLE_REG_AW-1:0] destReg;
    logic                     destRegValid;
    logic [BUNDLE_REG_AW-1:0] destRegSpecial;
    logic                     destRegSpecialValid;
    logic                     halt;
    logic [BUNDLE_RIP_W-1:0]  rip;
  } ex_wb_bundle_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_PRI = 2'd1,
    WR_SPC = 2'd2,
    HALT   = 2'd3
  } wb_state_t;

  // Scoreboard bits released when this bundle retires.
  function automatic logic [NUM_GPRS-1:0] clrMask(input ex_wb_bundle_t b);
    logic [NUM_GPRS-1:0] m;
    m = '0;
    if (b.destRegValid)        m[b.destReg]        = 1'b1;
    if (b.destRegSpecialValid) m[b.destRegSpecial] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_retire_counter.sv
// Retire pulse, retiring RIP and the free-running retired-instruction count.
// The count reflects retirements up to, but not including, the current pulse.
module wb_retire_counter #(
  parameter int RIP_W = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             retireIn,
  input  logic [RIP_W-1:0] retireRipIn,
  output logic             retire_valid,
  output logic [RIP_W-1:0] retire_rip,
  output logic [CNT_W-1:0] retire_count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      retire_valid <= 1'b0;
      retire_rip   <= '0;
      retire_count <= '0;
    end else begin
      retire_valid <= retireIn;
      retire_rip   <= retireIn ? retireRipIn : '0;
      retire_count <= retire_count + CNT_W'(retire_valid);
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Final pipeline stage: commits Execute results through a single register-file
// write port, serializing dual-destination results over two cycles.
module writeback_unit
  import pipeline_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int REG_AW = 4,
  parameter int RIP_W  = 32,
  parameter int CNT_W  = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ex_valid_in,
  output logic                 ex_ready_out,
  input  logic [DATA_W-1:0]    aluResultIn,
  input  logic [DATA_W-1:0]    aluResultSpecialIn,
  input  logic [REG_AW-1:0]    destRegIn,
  input  logic                 destRegValidIn,
  input  logic [REG_AW-1:0]    destRegSpecialIn,
  input  logic                 destRegSpecialValidIn,
  input  logic                 haltIn,
  input  logic [RIP_W-1:0]     currentRipIn,
  output logic                 rf_wr_en,
  output logic [REG_AW-1:0]    rf_wr_addr,
  output logic [DATA_W-1:0]    rf_wr_data,
  output logic [2**REG_AW-1:0] sb_clr_mask,
  output logic                 retire_valid,
  output logic [RIP_W-1:0]     retire_rip,
  output logic [CNT_W-1:0]     retire_count,
  output logic                 halted,
  output logic [1:0]           dbgState
);

  wb_state_t     state, nextState;
  ex_wb_bundle_t hold, inBundle;
  logic          accept, loadNew, enterSpc, retireNext;
  logic [RIP_W-1:0] retireRipNext;

  always_comb begin
    inBundle.result              = aluResultIn;
    inBundle.resultSpecial       = aluResultSpecialIn;
    inBundle.destReg             = destRegIn;
    inBundle.destRegValid        = destRegValidIn;
    inBundle.destRegSpecial      = destRegSpecialIn;
    inBundle.destRegSpecialValid = destRegSpecialValidIn;
    inBundle.halt                = haltIn;
    inBundle.rip                 = currentRipIn;
  end

  // Handshake: a bundle transfers on any edge where ex_valid_in && ex_ready_out;
  // Execute holds the bundle stable while ready is low. Ready is the only
  // combinational output and depends only on state and the holding register.
  assign ex_ready_out = (state == IDLE)
                     || (state == WR_PRI && !hold.destRegSpecialValid && !hold.halt)
                     || (state == WR_SPC && !hold.halt);
  assign accept   = ex_valid_in && ex_ready_out;
  assign dbgState = state;

  always_comb begin
    nextState = state;
    loadNew   = 1'b0;
    enterSpc  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          nextState = WR_PRI;
          loadNew   = 1'b1;
        end
      end
      WR_PRI, WR_SPC: begin
        if (state == WR_PRI && hold.destRegSpecialValid) begin
          nextState = WR_SPC;
          enterSpc  = 1'b1;
        end else if (hold.halt) begin
          nextState = HALT;
        end else if (accept) begin
          nextState = WR_PRI;
          loadNew   = 1'b1;
        end else begin
          nextState = IDLE;
        end
      end
      HALT:    nextState = HALT;
      default: nextState = IDLE;
    endcase
    // Outputs are registered, so retirement is decided on entry to the retire cycle.
    retireNext    = (loadNew && !inBundle.destRegSpecialValid) || enterSpc;
    retireRipNext = loadNew ? inBundle.rip : hold.rip;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      hold        <= '0;
      rf_wr_en    <= 1'b0;
      rf_wr_addr  <= '0;
      rf_wr_data  <= '0;
      sb_clr_mask <= '0;
      halted      <= 1'b0;
    end else begin
      state       <= nextState;
      rf_wr_en    <= 1'b0;
      rf_wr_addr  <= '0;
      rf_wr_data  <= '0;
      sb_clr_mask <= '0;
      if (loadNew) begin
        hold       <= inBundle;
        rf_wr_en   <= inBundle.destRegValid;
        rf_wr_addr <= inBundle.destRegValid ? inBundle.destReg : '0;
        rf_wr_data <= inBundle.destRegValid ? inBundle.result : '0;
        if (!inBundle.destRegSpecialValid) sb_clr_mask <= clrMask(inBundle);
      end else if (enterSpc) begin
        rf_wr_en    <= 1'b1;
        rf_wr_addr  <= hold.destRegSpecial;
        rf_wr_data  <= hold.resultSpecial;
        sb_clr_mask <= clrMask(hold);
      end
      if (nextState == HALT) halted <= 1'b1;
    end
  end

  wb_retire_counter #(
    .RIP_W(RIP_W),
    .CNT_W(CNT_W)
  ) u_retire (
    .clk         (clk),
    .reset       (reset),
    .retireIn    (retireNext),
    .retireRipIn (retireRipNext),
    .retire_valid(retire_valid),
    .retire_rip  (retire_rip),
    .retire_count(retire_count)
  );

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: directed scenarios plus randomized
// bundles checked against an in-order commit model.
module tb_writeback_unit;

  localparam int DATA_W = 64;
  localparam int REG_AW = 4;
  localparam int RIP_W  = 32;
  localparam int CNT_W  = 64;
  localparam int NREG   = 16;

  logic              clk, reset;
  logic              ex_valid_in, ex_ready_out;
  logic [DATA_W-1:0] aluResultIn, aluResultSpecialIn;
  logic [REG_AW-1:0] destRegIn, destRegSpecialIn;
  logic              destRegValidIn, destRegSpecialValidIn, haltIn;
  logic [RIP_W-1:0]  currentRipIn;
  logic              rf_wr_en;
  logic [REG_AW-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;
  logic [NREG-1:0]   sb_clr_mask;
  logic              retire_valid;
  logic [RIP_W-1:0]  retire_rip;
  logic [CNT_W-1:0]  retire_count;
  logic              halted;
  logic [1:0]        dbgState;

  writeback_unit dut (
    .clk(clk), .reset(reset),
    .ex_valid_in(ex_valid_in), .ex_ready_out(ex_ready_out),
    .aluResultIn(aluResultIn), .aluResultSpecialIn(aluResultSpecialIn),
    .destRegIn(destRegIn), .destRegValidIn(destRegValidIn),
    .destRegSpecialIn(destRegSpecialIn), .destRegSpecialValidIn(destRegSpecialValidIn),
    .haltIn(haltIn), .currentRipIn(currentRipIn),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .sb_clr_mask(sb_clr_mask), .retire_valid(retire_valid), .retire_rip(retire_rip),
    .retire_count(retire_count), .halted(halted), .dbgState(dbgState)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [REG_AW+DATA_W-1:0]     exp_q[$];
  logic [RIP_W+NREG+CNT_W-1:0]  ret_q[$];
  logic [DATA_W-1:0] modelRf[NREG];
  logic [DATA_W-1:0] dutRf[NREG];
  logic [CNT_W-1:0]  modelCount;
  bit modelHalted, lastDual, monEn;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic failNote(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  task automatic flushModel();
    exp_q.delete();
    ret_q.delete();
    modelCount  = '0;
    modelHalted = 0;
    lastDual    = 0;
  endtask

  task automatic chkOutputsZero(input string tag);
    chk({tag, "_wr_en"},   rf_wr_en, 0);
    chk({tag, "_wr_addr"}, rf_wr_addr, 0);
    chk({tag, "_wr_data"}, rf_wr_data, 0);
    chk({tag, "_sb_mask"}, sb_clr_mask, 0);
    chk({tag, "_ret_v"},   retire_valid, 0);
    chk({tag, "_ret_rip"}, retire_rip, 0);
    chk({tag, "_ret_cnt"}, retire_count, 0);
    chk({tag, "_halted"},  halted, 0);
  endtask

  // ---------------- driver tasks ----------------
  // Called and returning at posedge+1: a reset lasts exactly one edge.
  task automatic doReset(input string tag);
    reset       = 1'b1;
    ex_valid_in = 1'b0;
    @(posedge clk); #1;
    flushModel();
    chkOutputsZero(tag);
    reset = 1'b0;
    @(negedge clk);
    chk({tag, "_ready"}, ex_ready_out, 1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
    if (n > 0) lastDual = 0;
  endtask

  task automatic send(input logic [DATA_W-1:0] res, input logic [DATA_W-1:0] spcRes,
                      input logic [REG_AW-1:0] dst, input logic [REG_AW-1:0] spc,
                      input bit dv, input bit sv, input bit h, input logic [RIP_W-1:0] rip);
    int waited, expWait, limit;
    bit accepted;
    logic [NREG-1:0] m;
    waited   = 0;
    accepted = 0;
    expWait  = lastDual ? 1 : 0;
    limit    = modelHalted ? 6 : 10;
    aluResultIn = res; aluResultSpecialIn = spcRes;
    destRegIn = dst; destRegSpecialIn = spc;
    destRegValidIn = dv; destRegSpecialValidIn = sv;
    haltIn = h; currentRipIn = rip;
    ex_valid_in = 1'b1;
    while (1) begin
      @(negedge clk);
      if (ex_ready_out === 1'b1) begin accepted = 1; break; end
      waited++;
      if (waited >= limit) break;
    end
    if (modelHalted) chk("halt_blocks_accept", accepted, 0);
    else if (!accepted) failNote("accept_timeout");
    else chk("ready_wait_cycles", waited, expWait);
    if (accepted) begin
      m = '0;
      if (dv) begin exp_q.push_back({dst, res});    modelRf[dst] = res;    m[dst] = 1'b1; end
      if (sv) begin exp_q.push_back({spc, spcRes}); modelRf[spc] = spcRes; m[spc] = 1'b1; end
      ret_q.push_back({rip, m, modelCount});
      modelCount  = modelCount + 1;
      modelHalted = h;
      lastDual    = sv;
    end else begin
      lastDual = 0;
    end
    @(posedge clk); #1;
    ex_valid_in = 1'b0;
  endtask

  // ---------------- monitor ----------------
  logic [REG_AW+DATA_W-1:0]    monW;
  logic [RIP_W+NREG+CNT_W-1:0] monR;
  always @(negedge clk) begin
    if (monEn) begin
      if (rf_wr_en) begin
        if (exp_q.size() == 0) failNote("unexpected_write");
        else begin
          monW = exp_q.pop_front();
          chk("wr_addr", rf_wr_addr, monW[REG_AW+DATA_W-1:DATA_W]);
          chk("wr_data", rf_wr_data, monW[DATA_W-1:0]);
        end
        dutRf[rf_wr_addr] = rf_wr_data;
      end
      if (retire_valid) begin
        if (ret_q.size() == 0) failNote("unexpected_retire");
        else begin
          monR = ret_q.pop_front();
          chk("retire_rip",   retire_rip,   monR[RIP_W+NREG+CNT_W-1:NREG+CNT_W]);
          chk("sb_clr_mask",  sb_clr_mask,  monR[NREG+CNT_W-1:CNT_W]);
          chk("retire_count", retire_count, monR[CNT_W-1:0]);
        end
      end else begin
        chk("sb_mask_quiet", sb_clr_mask, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [REG_AW-1:0] d, s;
    logic [DATA_W-1:0] oldR2;
    bit dv, sv;
    reset = 1'b1; ex_valid_in = 1'b0;
    aluResultIn = '0; aluResultSpecialIn = '0; destRegIn = '0; destRegSpecialIn = '0;
    destRegValidIn = 1'b0; destRegSpecialValidIn = 1'b0; haltIn = 1'b0; currentRipIn = '0;
    for (int i = 0; i < NREG; i++) begin modelRf[i] = '0; dutRf[i] = '0; end
    monEn = 0;
    flushModel();
    doReset("reset");
    monEn = 1;

    // single-destination ADD, first write one cycle after transfer
    send(64'h5, 64'h0, 4'd3, 4'd0, 1, 0, 0, 32'h100);
    chk("add_latency_wr_en", rf_wr_en, 1);
    chk("add_count_before", retire_count, 0);
    idle(1);
    chk("add_count_after", retire_count, 1);

    // back-to-back single-destination bundles
    doReset("reset2");
    send(64'hA, 64'h0, 4'd1, 4'd0, 1, 0, 0, 32'h200);
    send(64'hB, 64'h0, 4'd2, 4'd0, 1, 0, 0, 32'h204);
    send(64'hC, 64'h0, 4'd4, 4'd0, 1, 0, 0, 32'h208);
    idle(2);
    chk("b2b_count", retire_count, 3);

    // MUL: RAX low, RDX high; next bundle has to wait one cycle
    send(64'h1111, 64'h2222, 4'd0, 4'd2, 1, 1, 0, 32'h300);
    chk("mul_ready_low", ex_ready_out, 0);
    send(64'h77, 64'h0, 4'd7, 4'd0, 1, 0, 0, 32'h304);
    idle(2);

    // dual write to the same register: second write wins
    send(64'h7, 64'h9, 4'd5, 4'd5, 1, 1, 0, 32'h400);
    idle(3);
    chk("same_reg_final", dutRf[5], 64'h9);

    // halting instruction retires, then nothing more is accepted
    send(64'h0, 64'h0, 4'd0, 4'd0, 0, 0, 1, 32'h500);
    idle(1);
    chk("halt_sticky", halted, 1);
    chk("halt_ready_low", ex_ready_out, 0);
    for (int i = 0; i < 3; i++)
      send(64'(32'hD0 + i), 64'h0, 4'(i + 8), 4'd0, 1, 0, 0, 32'h600 + 32'(i));
    chk("halt_still", halted, 1);
    chk("halt_count", retire_count, modelCount);
    doReset("reset_halt");

    // reset during WR_PRI of a MUL drops the pending high-half write
    send(64'h3333, 64'h4444, 4'd0, 4'd0, 1, 0, 0, 32'h700);
    idle(1);
    oldR2 = modelRf[2];
    send(64'h5555, 64'h6666, 4'd0, 4'd2, 1, 1, 0, 32'h704);
    doReset("reset_mid");
    modelRf[2] = oldR2;
    idle(2);
    chk("mid_no_spc_write", dutRf[2], oldR2);

    // randomized bundles
    for (int n = 0; n < 300; n++) begin
      d  = 4'($urandom_range(0, NREG - 1));
      s  = 4'($urandom_range(0, NREG - 1));
      dv = ($urandom_range(0, 3) != 0);
      sv = ($urandom_range(0, 3) == 0);
      send({$urandom, $urandom}, {$urandom, $urandom}, d, s, dv, sv, 0, $urandom);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(4);

    chk("write_queue_drained", exp_q.size(), 0);
    chk("retire_queue_drained", ret_q.size(), 0);
    chk("final_retire_count", retire_count, modelCount);
    for (int i = 0; i < NREG; i++) chk("final_regfile", dutRf[i], modelRf[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Final pipeline stage. Consumes Execute's result bundle through a valid/ready handshake and commits it to the architectural register file.
- The register file has a single write port. Dual-destination results (MUL/IMUL F7: RAX low half, RDX high half) are serialized over two cycles.
- Each commit clears the matching scoreboard busy bits, counts retired instructions and latches a sticky halt on RET-class instructions.

Parameters:
- DATA_W, 64, width of result and write data.
- REG_AW, 4, register index width (16 GPRs).
- RIP_W, 32, instruction pointer width.
- CNT_W, 64, retire counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ex_valid_in  in  1  Execute presents a result bundle.
- ex_ready_out  out  1  writeback accepts the bundle this cycle.
- aluResultIn  in  DATA_W  primary result.
- aluResultSpecialIn  in  DATA_W  secondary result (high half of a multiply).
- destRegIn  in  REG_AW  primary destination.
- destRegValidIn  in  1  primary write required (0 for CMP and other no-write ops).
- destRegSpecialIn  in  REG_AW  secondary destination.
- destRegSpecialValidIn  in  1  secondary write required.
- haltIn  in  1  instruction is RET/RETF/IRET.
- currentRipIn  in  RIP_W  RIP of the instruction.
- rf_wr_en  out  1  register file write strobe.
- rf_wr_addr  out  REG_AW  write index.
- rf_wr_data  out  DATA_W  write data.
- sb_clr_mask  out  2**REG_AW  one-cycle scoreboard clear bits.
- retire_valid  out  1  one-cycle pulse when an instruction completes.
- retire_rip  out  RIP_W  RIP of the retiring instruction.
- retire_count  out  CNT_W  instructions retired since reset.
- halted  out  1  sticky halt.

Behaviour:
- Handshake: transfer occurs when ex_valid_in && ex_ready_out. The bundle is captured into a holding register on that edge. Execute must hold its inputs stable while ex_ready_out=0.
- All outputs except ex_ready_out are driven from registered state only. There is no combinational input-to-output path except the ready logic.
- States: IDLE, WR_PRI, WR_SPC, HALT.
- IDLE: rf_wr_en=0. On transfer, go to WR_PRI.
- WR_PRI (one cycle):
  - rf_wr_en=destRegValid_h, addr=destReg_h, data=aluResult_h.
  - If destRegSpecialValid_h, go to WR_SPC.
  - Otherwise retire this cycle. Next state is HALT if halt_h, else WR_PRI if a new transfer occurs, else IDLE.
- WR_SPC (one cycle):
  - rf_wr_en=1, addr=destRegSpecial_h, data=aluResultSpecial_h.
  - Retire this cycle. Next state follows the same rules as WR_PRI's retire case.
- ex_ready_out = (IDLE) || (WR_PRI && !destRegSpecialValid_h && !halt_h) || (WR_SPC && !halt_h).
- Throughput: 1 instruction/cycle for single-destination results, 2 cycles for dual-destination results. Latency from transfer to first write is 1 cycle.
- Retire cycle:
  - retire_valid=1, retire_rip=rip_h, retire_count increments on the following edge (wraps modulo 2**CNT_W).
  - sb_clr_mask sets bit destReg_h if destRegValid_h and bit destRegSpecial_h if destRegSpecialValid_h. It is asserted only in the retire cycle and is 0 otherwise.
- Same-register dual write (destReg_h == destRegSpecial_h, both valid): both writes are issued; the special (second) write wins. sb_clr_mask sets that single bit.
- Bundle with neither write valid (e.g. CMP): WR_PRI issues no write and retires normally.
- HALT: ex_ready_out=0, no writes, halted=1. Only reset exits HALT. The halting instruction itself retires (counted, retire_rip valid) before entering HALT.
- Reset (also mid-operation):
  - state=IDLE; the holding register is invalidated and any pending WR_SPC write is dropped.
  - rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, sb_clr_mask=0, retire_valid=0, retire_rip=0, retire_count=0, halted=0.
  - ex_ready_out=1 in the first cycle after reset deasserts.

Decomposition:
- Shared package pipeline_pkg:
  - typedef ex_wb_bundle_t (result, special result, dest regs, valid bits, halt, rip).
  - enum wb_state_t.
  - constants NUM_GPRS=16, REG_RAX=0, REG_RDX=2.
- Sub-module: wb_retire_counter (counter plus retire pulse/rip register). Everything else stays in writeback_unit.

Test Plan:
- ADD result 0x5 to dest 3, single dest, after reset -> next cycle: rf_wr_en=1, addr=3, data=0x5; sb_clr_mask=0x0008; retire_count 0->1.
- Back-to-back valid bundles to dest 1 (0xA), dest 2 (0xB), dest 4 (0xC) -> ex_ready_out stays 1; writes on 3 consecutive cycles; retire_count=3.
- MUL, result 0x1111, special 0x2222, dest 0 / special 2 -> cycle1 writes r0=0x1111, cycle2 writes r2=0x2222; ex_ready_out=0 during cycle1; sb_clr_mask=0x0005 in cycle2 only.
- Dual write with both destinations = 5, data 0x7 then 0x9 -> two writes to r5, final value 0x9; sb_clr_mask=0x0020.
- haltIn=1 with dest invalid, then further valid bundles -> one retire pulse, halted=1, ex_ready_out=0 thereafter, no further rf_wr_en until reset.
- Reset asserted in WR_PRI of a MUL bundle -> no WR_SPC write, all outputs zero, retire_count=0, ex_ready_out=1 after reset release.
